// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing the single write port of the asynchronous
//   FIFO between NUM_REQ producers, all in the wclk domain. A requester is
//   granted the port for a burst of up to MAX_BURST words. Every grant is
//   followed by one idle cycle. winc is never asserted while wfull is high
//   or while wrst is high.
//
//   Parameters: NUM_REQ (2..8), DATA_WIDTH, MAX_BURST (1..16).
//   Ports:
//     wclk      - write-domain clock
//     wrst      - synchronous active-high reset
//     req       - per-requester level request
//     req_data  - requester i word on [i*DATA_WIDTH +: DATA_WIDTH]
//     wfull     - FIFO full flag
//     gnt       - registered one-hot grant (zero when idle)
//     ack       - one-hot strobe, word of that requester accepted this cycle
//     winc      - FIFO write enable
//     wdata     - FIFO write data (owner's slice while writing, else zero)
//     busy      - high while a grant is active (BURST state)
//     stall_cnt - cycles where the owner wanted to write but the FIFO was full
//
//   Optional build macro FIFO_WR_ARB_STATS_EN: enables the saturating
//   stall_cnt counter. Without it, stall_cnt is tied to zero.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          wfull,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          busy,
    output logic [15:0]                   stall_cnt
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(MAX_BURST - 1);
    localparam logic [OW-1:0] LAST_RST  = OW'(NUM_REQ - 1);
    localparam logic [OW:0]   NUM_REQ_W = (OW + 1)'(NUM_REQ);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t              state_reg;
    logic [OW-1:0]       owner_reg;
    logic [OW-1:0]       last_reg;
    logic [BW-1:0]       bcnt_reg;
    logic [NUM_REQ-1:0]  gnt_reg;

    logic [DATA_WIDTH-1:0] slice [NUM_REQ];
    logic [NUM_REQ-1:0]    owner_onehot;
    logic                  owner_req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign slice[gi]        = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign owner_onehot[gi] = (owner_reg == OW'(gi));
        end
    endgenerate

    assign owner_req = req[owner_reg];
    assign busy      = (state_reg == ST_BURST);
    // wrst gating keeps the FIFO from seeing a write in the reset cycle,
    // since state only clears at the edge that ends that cycle.
    assign winc      = busy & owner_req & ~wfull & ~wrst;
    assign ack       = winc ? owner_onehot : '0;
    assign wdata     = winc ? slice[owner_reg] : '0;
    assign gnt       = gnt_reg;

    // Round-robin pick: rotate req so that index last+1 lands at bit 0,
    // find the lowest set bit, then map the offset back to an absolute index.
    logic [OW:0]          base;
    logic [2*NUM_REQ-1:0] req_rot_wide;
    logic [NUM_REQ-1:0]   req_rot;
    logic [OW:0]          offset;
    logic [OW:0]          pick_sum;
    logic [OW-1:0]        pick;

    always_comb begin
        base         = {1'b0, last_reg} + (OW + 1)'(1);
        req_rot_wide = {req, req} >> base;
        req_rot      = req_rot_wide[NUM_REQ-1:0];
        offset       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = (OW + 1)'(k);
            end
        end
        pick_sum = base + offset;
        if (pick_sum >= NUM_REQ_W) begin
            pick_sum = pick_sum - NUM_REQ_W;
        end
        pick = pick_sum[OW-1:0];
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_reg <= ST_IDLE;
            owner_reg <= '0;
            last_reg  <= LAST_RST;
            bcnt_reg  <= '0;
            gnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        owner_reg <= pick;
                        last_reg  <= pick;
                        gnt_reg   <= NUM_REQ'(1) << pick;
                        bcnt_reg  <= '0;
                        state_reg <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (!owner_req) begin
                        // Owner withdrew: end the burst without a transfer.
                        state_reg <= ST_IDLE;
                        gnt_reg   <= '0;
                        bcnt_reg  <= '0;
                    end else if (!wfull) begin
                        if (bcnt_reg == BCNT_LAST) begin
                            state_reg <= ST_IDLE;
                            gnt_reg   <= '0;
                            bcnt_reg  <= '0;
                        end else begin
                            bcnt_reg <= bcnt_reg + BW'(1);
                        end
                    end
                    // wfull with owner still requesting: hold everything.
                end
                default: begin
                    state_reg <= ST_IDLE;
                    gnt_reg   <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            stall_cnt_reg <= '0;
        end else if (busy && owner_req && wfull && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter. One instance uses the default
// parameters (4 requesters, bursts of 4); a second uses MAX_BURST=1.
module tb_fifo_wr_arbiter;

    logic        wclk;
    logic        wrst;

    logic [3:0]  req;
    logic [31:0] req_data;
    logic        wfull;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        winc;
    logic [7:0]  wdata;
    logic        busy;
    logic [15:0] stall_cnt;

    logic [3:0]  req1;
    logic [31:0] req_data1;
    logic        wfull1;
    logic [3:0]  gnt1;
    logic [3:0]  ack1;
    logic        winc1;
    logic [7:0]  wdata1;
    logic        busy1;
    logic [15:0] stall_cnt1;

    int n_cmp = 0;
    int n_err = 0;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data),
        .wfull(wfull), .gnt(gnt), .ack(ack), .winc(winc), .wdata(wdata),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut_mb1 (
        .wclk(wclk), .wrst(wrst), .req(req1), .req_data(req_data1),
        .wfull(wfull1), .gnt(gnt1), .ack(ack1), .winc(winc1), .wdata(wdata1),
        .busy(busy1), .stall_cnt(stall_cnt1)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        nxt();
        nxt();
        wrst = 1'b0;
    endtask

    // A write while full must never happen on either instance.
    always @(negedge wclk) begin
        check("no_winc_while_full", {31'b0, winc & wfull}, 32'd0);
        check("no_winc_while_full_mb1", {31'b0, winc1 & wfull1}, 32'd0);
    end

    int          order[5] = '{0, 1, 2, 3, 0};
    logic [3:0]  eo;
    logic [15:0] exp_stall;

    initial begin
        wrst = 1'b1; req = '0; req_data = '0; wfull = 1'b0;
        req1 = '0; req_data1 = '0; wfull1 = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
        exp_stall = 16'd3;
`else
        exp_stall = 16'd0;
`endif

        // ---- Reset values
        do_reset();
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_winc", winc, 0);
        check("rst_busy", busy, 0);
        check("rst_wdata", wdata, 0);
        check("rst_stall", stall_cnt, 0);

        // ---- Single requester 2, full burst of 4 words
        req = 4'b0100; req_data[23:16] = 8'hA0;
        #1;
        check("t1_idle_gnt", gnt, 0);
        nxt();
        for (int i = 0; i < 4; i++) begin
            req_data[23:16] = 8'hA0 + 8'(i);
            #1;
            check("t1_gnt", gnt, 4'b0100);
            check("t1_winc", winc, 1);
            check("t1_ack", ack, 4'b0100);
            check("t1_wdata", wdata, 8'hA0 + 8'(i));
            $display("t1 word %0d owner 2 data %h", i, wdata);
            nxt();
        end
        req = 4'b0000;
        #1;
        check("t1_end_gnt", gnt, 0);
        check("t1_end_winc", winc, 0);
        check("t1_end_busy", busy, 0);

        // ---- All requesting: order 0,1,2,3,0 with one bubble between bursts
        do_reset();
        req_data = 32'h33221100;
        req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            eo = 4'b0001 << order[b];
            #1;
            check("t2_bubble_gnt", gnt, 0);
            check("t2_bubble_winc", winc, 0);
            nxt();
            for (int w = 0; w < 4; w++) begin
                #1;
                check("t2_gnt", gnt, eo);
                check("t2_ack", ack, eo);
                check("t2_winc", winc, 1);
                check("t2_wdata", wdata, 32'(order[b] * 17));
                $display("t2 burst %0d word %0d owner %0d data %h", b, w, order[b], wdata);
                nxt();
            end
        end
        req = 4'b0000;
        nxt();

        // ---- Owner 1 stalled by wfull for 3 cycles after 2 words
        do_reset();
        req = 4'b0010; req_data[15:8] = 8'h5A;
        nxt();
        for (int w = 0; w < 2; w++) begin
            #1;
            check("t3_winc_pre", winc, 1);
            check("t3_ack_pre", ack, 4'b0010);
            nxt();
        end
        wfull = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("t3_stall_winc", winc, 0);
            check("t3_stall_ack", ack, 0);
            check("t3_stall_gnt", gnt, 4'b0010);
            check("t3_stall_busy", busy, 1);
            $display("t3 stall cycle %0d", s);
            nxt();
        end
        wfull = 1'b0;
        for (int w = 2; w < 4; w++) begin
            #1;
            check("t3_winc_post", winc, 1);
            check("t3_ack_post", ack, 4'b0010);
            check("t3_wdata", wdata, 8'h5A);
            nxt();
        end
        req = 4'b0000;
        #1;
        check("t3_end_gnt", gnt, 0);
        check("t3_stall_cnt", stall_cnt, exp_stall);

        // ---- Owner 3 drops req after one word; requester 0 is next
        do_reset();
        req = 4'b1000;
        nxt();
        #1;
        check("t4_gnt3", gnt, 4'b1000);
        check("t4_winc", winc, 1);
        check("t4_ack", ack, 4'b1000);
        nxt();
        req = 4'b0001;
        #1;
        check("t4_drop_winc", winc, 0);
        check("t4_drop_ack", ack, 0);
        nxt();
        #1;
        check("t4_idle_gnt", gnt, 0);
        check("t4_idle_winc", winc, 0);
        nxt();
        #1;
        check("t4_gnt0", gnt, 4'b0001);
        check("t4_ack0", ack, 4'b0001);
        req = 4'b0000;
        nxt();
        nxt();

        // ---- Reset during the second word of a burst
        do_reset();
        req = 4'b0100;
        nxt();
        #1;
        check("t5_word1_winc", winc, 1);
        nxt();
        wrst = 1'b1;
        #1;
        check("t5_rstcyc_winc", winc, 0);
        check("t5_rstcyc_ack", ack, 0);
        nxt();
        #1;
        check("t5_rst_gnt", gnt, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_winc", winc, 0);
        check("t5_rst_ack", ack, 0);
        check("t5_rst_wdata", wdata, 0);
        check("t5_rst_stall", stall_cnt, 0);
        wrst = 1'b0;
        req = 4'b1010;
        #1;
        check("t5_idle_gnt", gnt, 0);
        nxt();
        #1;
        check("t5_gnt1", gnt, 4'b0010);
        req = 4'b0000;
        nxt();
        nxt();

        // ---- MAX_BURST=1: alternating single words 0,1,0,1
        req_data1 = 32'h0000B1B0;
        req1 = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            eo = 4'b0001 << (i % 2);
            #1;
            check("t6_bubble_gnt", gnt1, 0);
            check("t6_bubble_winc", winc1, 0);
            nxt();
            if (i == 2) begin
                wfull1 = 1'b1;
                #1;
                check("t6_full_winc", winc1, 0);
                check("t6_full_gnt", gnt1, eo);
                nxt();
                wfull1 = 1'b0;
            end
            #1;
            check("t6_gnt", gnt1, eo);
            check("t6_ack", ack1, eo);
            check("t6_winc", winc1, 1);
            check("t6_wdata", wdata1, (i % 2 == 0) ? 32'hB0 : 32'hB1);
            $display("t6 word %0d owner %0d data %h", i, i % 2, wdata1);
            nxt();
        end
        req1 = 4'b0000;
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
